// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/interlock scoreboard.
//
// fwd_entry_t stores dst and avail at fixed maximum widths so one struct serves every
// parameterisation; narrower fields are zero-extended on entry. AW must not exceed
// FWD_AW_MAX and DEPTH must fit in FWD_AVAIL_W bits.
package fwd_pkg;

  localparam int unsigned FWD_AW_MAX  = 8;
  localparam int unsigned FWD_AVAIL_W = 8;

  // Forward-select value meaning "read the register file".
  localparam int unsigned FWD_SEL_RF = 0;

  // First stage at whose output the result exists.
  localparam int unsigned AVAIL_ALU  = 1;
  localparam int unsigned AVAIL_LOAD = 2;

  typedef struct packed {
    logic                   v;
    logic                   wen;
    logic [FWD_AW_MAX-1:0]  dst;
    logic [FWD_AVAIL_W-1:0] avail;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// One source operand versus the shadow pipeline entries.
//
// Ports:
//   src_i       source register address
//   used_i      source is read (already qualified with ID valid by the caller)
//   entries_i   shadow entries, index 0 = stage 1 (EX) .. DEPTH-1 = stage DEPTH (WB)
//   sel_o       0 = register file, k = forward from output of stage k
//   not_ready_o youngest producer has not yet produced its result
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SELW  = 2
) (
  input  logic [AW-1:0]   src_i,
  input  logic            used_i,
  input  fwd_entry_t      entries_i [DEPTH],
  output logic [SELW-1:0] sel_o,
  output logic            not_ready_o
);

  logic [FWD_AW_MAX-1:0] src_ext;
  logic                  found;

  assign src_ext = FWD_AW_MAX'(src_i);

  // Scan from the youngest stage; the first hit decides, older producers are ignored.
  always_comb begin
    sel_o       = SELW'(FWD_SEL_RF);
    not_ready_o = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (!found && used_i && entries_i[k].v && entries_i[k].wen &&
          (entries_i[k].dst == src_ext) && (entries_i[k].dst != '0)) begin
        found = 1'b1;
        if (k + 1 >= int'(entries_i[k].avail)) begin
          sel_o = SELW'(k + 1);
        end else begin
          not_ready_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and interlock unit beside the ID stage of the in-order pipeline.
//
// Keeps a shadow copy of destination tags for the DEPTH stages after ID, selects the
// youngest producer per source and either forwards from it or stalls ID.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   id_valid_i       valid instruction in ID
//   id_src_i         NSRC source addresses, source j at [j*AW +: AW]
//   id_src_used_i    per-source read enable
//   id_wen_i         instruction writes a register
//   id_dst_i         destination address
//   id_avail_i       first stage (1..DEPTH) whose output holds the result
//   hold_i           global freeze
//   flush_i          kill instructions in ID and EX
//   fwd_sel_o        per-source forward select, SELW bits each
//   stall_o          ID must not issue
//   issue_o          ID instruction enters stage 1 this cycle
//   stall_cycles_o   saturating stall counter, only when FWD_STALL_CNT_EN is defined
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int unsigned AW    = 5,
  parameter  int unsigned NSRC  = 2,
  parameter  int unsigned DEPTH = 3,
  localparam int unsigned SELW  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid_i,
  input  logic [NSRC*AW-1:0]   id_src_i,
  input  logic [NSRC-1:0]      id_src_used_i,
  input  logic                 id_wen_i,
  input  logic [AW-1:0]        id_dst_i,
  input  logic [SELW-1:0]      id_avail_i,
  input  logic                 hold_i,
  input  logic                 flush_i,
  output logic [NSRC*SELW-1:0] fwd_sel_o,
  output logic                 stall_o,
  output logic                 issue_o
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles_o
`endif
);

  fwd_entry_t      entry_q [DEPTH];
  fwd_entry_t      entry_d [DEPTH];
  fwd_entry_t      id_entry;
  logic [NSRC-1:0] not_ready;

  for (genvar j = 0; j < NSRC; j++) begin : g_src
    fwd_match #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .SELW  (SELW)
    ) u_match (
      .src_i       (id_src_i[j*AW +: AW]),
      .used_i      (id_src_used_i[j] & id_valid_i),
      .entries_i   (entry_q),
      .sel_o       (fwd_sel_o[j*SELW +: SELW]),
      .not_ready_o (not_ready[j])
    );
  end

  assign stall_o = id_valid_i & (|not_ready);
  // Flush outranks stall; hold blocks issue but stall/fwd_sel still reflect current state.
  assign issue_o = id_valid_i & ~stall_o & ~hold_i & ~flush_i;

  always_comb begin
    id_entry       = '0;
    id_entry.v     = 1'b1;
    id_entry.wen   = id_wen_i;
    id_entry.dst   = FWD_AW_MAX'(id_dst_i);
    id_entry.avail = FWD_AVAIL_W'(id_avail_i);
  end

  always_comb begin
    entry_d = entry_q;
    if (!hold_i) begin
      entry_d[0] = issue_o ? id_entry : '0;
      // Flush drops the EX occupant instead of letting it move to stage 2.
      for (int k = 1; k < int'(DEPTH); k++) begin
        entry_d[k] = (k == 1 && flush_i) ? '0 : entry_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        entry_q[k] <= '0;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && !hold_i && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

endmodule
